// File: rtl/jedro_1_defines.sv
// Shared widths and ALU operation encodings ({funct7[5], funct3}) for the jedro_1 core.
package jedro_1_defines;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_OP_WIDTH   = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_OP_ADD  = 4'b0000,
    ALU_OP_SLL  = 4'b0001,
    ALU_OP_SLT  = 4'b0010,
    ALU_OP_SLTU = 4'b0011,
    ALU_OP_XOR  = 4'b0100,
    ALU_OP_SRL  = 4'b0101,
    ALU_OP_OR   = 4'b0110,
    ALU_OP_AND  = 4'b0111,
    ALU_OP_SUB  = 4'b1000,
    ALU_OP_SRA  = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/jedro_1_alu_shifter.sv
// Combinational barrel shifter: left, logical right or arithmetic right by shamt.
module jedro_1_alu_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  input  logic                   right_i,
  input  logic                   arith_i,
  output logic [DATA_WIDTH-1:0]  res_o
);

  always_comb begin
    res_o = '0;
    if (!right_i) begin
      res_o = a_i << shamt_i;
    end else if (arith_i) begin
      res_o = DATA_WIDTH'($signed(a_i) >>> shamt_i);
    end else begin
      res_o = a_i >> shamt_i;
    end
  end

endmodule

// File: rtl/jedro_1_alu_stage.sv
// jedro_1 execute stage: one-cycle registered ALU with dest address / write-back pass-through.
module jedro_1_alu_stage #(
  parameter int DATA_WIDTH     = jedro_1_defines::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = jedro_1_defines::REG_ADDR_WIDTH,
  parameter int ALU_OP_WIDTH   = jedro_1_defines::ALU_OP_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [ALU_OP_WIDTH-1:0]   alu_op_sel_i,
  input  logic [DATA_WIDTH-1:0]     opa_i,
  input  logic [DATA_WIDTH-1:0]     opb_i,
  output logic [DATA_WIDTH-1:0]     res_o,
  output logic                      overflow_o,
  input  logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_addr_i,
  output logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_addr_o,
  input  logic                      alu_reg_wb_i,
  output logic                      alu_reg_wb_o
);
  import jedro_1_defines::*;

  localparam int MSB         = DATA_WIDTH - 1;
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]     sum, diff, shift_res;
  logic [DATA_WIDTH-1:0]     res_d, res_q;
  logic                      ovf_d, ovf_q;
  logic                      legal;
  logic                      wb_d, wb_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;

  // op bit 2 separates SRL/SRA from SLL; op bit 3 (funct7[5]) selects arithmetic.
  jedro_1_alu_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shifter (
    .a_i    (opa_i),
    .shamt_i(opb_i[SHAMT_WIDTH-1:0]),
    .right_i(alu_op_sel_i[2]),
    .arith_i(alu_op_sel_i[3]),
    .res_o  (shift_res)
  );

  always_comb begin
    sum   = opa_i + opb_i;
    diff  = opa_i - opb_i;
    res_d = '0;
    ovf_d = 1'b0;
    legal = 1'b1;
    case (alu_op_sel_i)
      ALU_OP_ADD: begin
        res_d = sum;
        ovf_d = (opa_i[MSB] == opb_i[MSB]) && (sum[MSB] != opa_i[MSB]);
      end
      ALU_OP_SUB: begin
        res_d = diff;
        ovf_d = (opa_i[MSB] != opb_i[MSB]) && (diff[MSB] != opa_i[MSB]);
      end
      ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA: res_d = shift_res;
      ALU_OP_SLT:  res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(opa_i) < $signed(opb_i))};
      ALU_OP_SLTU: res_d = {{(DATA_WIDTH-1){1'b0}}, (opa_i < opb_i)};
      ALU_OP_XOR:  res_d = opa_i ^ opb_i;
      ALU_OP_OR:   res_d = opa_i | opb_i;
      ALU_OP_AND:  res_d = opa_i & opb_i;
      default:     legal = 1'b0;
    endcase
    wb_d = alu_reg_wb_i & legal;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      res_q  <= '0;
      ovf_q  <= 1'b0;
      dest_q <= '0;
      wb_q   <= 1'b0;
    end else begin
      res_q  <= res_d;
      ovf_q  <= ovf_d;
      dest_q <= reg_alu_dest_addr_i;
      wb_q   <= wb_d;
    end
  end

  assign res_o               = res_q;
  assign overflow_o          = ovf_q;
  assign reg_alu_dest_addr_o = dest_q;
  assign alu_reg_wb_o        = wb_q;

endmodule

// File: tb/tb_jedro_1_alu_stage.sv
// Self-checking bench for jedro_1_alu_stage: directed vectors plus random ops against an arithmetic model.
module tb_jedro_1_alu_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [3:0]  alu_op_sel_i;
  logic [31:0] opa_i, opb_i;
  logic [31:0] res_o;
  logic        overflow_o;
  logic [4:0]  reg_alu_dest_addr_i, reg_alu_dest_addr_o;
  logic        alu_reg_wb_i, alu_reg_wb_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  jedro_1_alu_stage #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(5),
    .ALU_OP_WIDTH  (4)
  ) dut (
    .clk_i              (clk_i),
    .rstn_i             (rstn_i),
    .alu_op_sel_i       (alu_op_sel_i),
    .opa_i              (opa_i),
    .opb_i              (opb_i),
    .res_o              (res_o),
    .overflow_o         (overflow_o),
    .reg_alu_dest_addr_i(reg_alu_dest_addr_i),
    .reg_alu_dest_addr_o(reg_alu_dest_addr_o),
    .alu_reg_wb_i       (alu_reg_wb_i),
    .alu_reg_wb_o       (alu_reg_wb_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32I semantics from plain signed/unsigned arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ovf, output logic legal);
    longint sa, sb, wide;
    int     ia;
    int unsigned sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    sh = b % 32;
    res = 32'h0; ovf = 1'b0; legal = 1'b1;
    case (op)
      4'b0000: begin wide = sa + sb; res = wide[31:0]; ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'b1000: begin wide = sa - sb; res = wide[31:0]; ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'b0001: res = a << sh;
      4'b0010: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b0011: res = (a < b) ? 32'd1 : 32'd0;
      4'b0100: res = a ^ b;
      4'b0101: res = a >> sh;
      4'b1101: res = ia >>> sh;
      4'b0110: res = a | b;
      4'b0111: res = a & b;
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic wb);
    @(negedge clk_i);
    alu_op_sel_i = op; opa_i = a; opb_i = b; reg_alu_dest_addr_i = d; alu_reg_wb_i = wb;
  endtask

  task automatic directed(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic wb,
                          input logic [31:0] eres, input logic eovf, input logic ewb);
    drive(op, a, b, d, wb);
    @(posedge clk_i); #1;
    chk({tag, ".res"}, res_o, eres);
    chk({tag, ".ovf"}, {31'h0, overflow_o}, {31'h0, eovf});
    chk({tag, ".dest"}, {27'h0, reg_alu_dest_addr_o}, {27'h0, d});
    chk({tag, ".wb"}, {31'h0, alu_reg_wb_o}, {31'h0, ewb});
  endtask

  logic [31:0] rres, ra, rb;
  logic        rovf, rlegal, rwb;
  logic [3:0]  rop;
  logic [4:0]  rd;
  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000001F};

  initial begin
    rstn_i = 1'b0;
    alu_op_sel_i = 4'b0000; opa_i = 32'd3; opb_i = 32'd4; reg_alu_dest_addr_i = 5'd7; alu_reg_wb_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst.res", res_o, 32'h0);
    chk("rst.ovf", {31'h0, overflow_o}, 32'h0);
    chk("rst.dest", {27'h0, reg_alu_dest_addr_o}, 32'h0);
    chk("rst.wb", {31'h0, alu_reg_wb_o}, 32'h0);
    @(negedge clk_i); rstn_i = 1'b1; #1;
    chk("rel.res_hold", res_o, 32'h0);
    @(posedge clk_i); #1;
    chk("rel.res", res_o, 32'd7);
    chk("rel.dest", {27'h0, reg_alu_dest_addr_o}, 32'd7);
    chk("rel.wb", {31'h0, alu_reg_wb_o}, 32'd1);

    directed("add_ovf", 4'b0000, 32'h7FFFFFFF, 32'h1, 5'd5, 1'b1, 32'h80000000, 1'b1, 1'b1);
    directed("sub",     4'b1000, 32'd5, 32'd7,        5'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1);
    directed("add_wrap",4'b0000, 32'hFFFFFFFF, 32'h1, 5'd5, 1'b1, 32'h0, 1'b0, 1'b1);
    directed("sub_ovf", 4'b1000, 32'h80000000, 32'h1, 5'd6, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    directed("slt",     4'b0010, 32'hFFFFFFFF, 32'h1, 5'd1, 1'b1, 32'h1, 1'b0, 1'b1);
    directed("sltu",    4'b0011, 32'hFFFFFFFF, 32'h1, 5'd1, 1'b1, 32'h0, 1'b0, 1'b1);
    directed("slt_eq",  4'b0010, 32'h1234, 32'h1234,  5'd1, 1'b1, 32'h0, 1'b0, 1'b1);
    directed("sltu_eq", 4'b0011, 32'h1234, 32'h1234,  5'd1, 1'b1, 32'h0, 1'b0, 1'b1);
    directed("sll",     4'b0001, 32'h80000001, 32'h24, 5'd2, 1'b1, 32'h00000010, 1'b0, 1'b1);
    directed("srl",     4'b0101, 32'h80000001, 32'h24, 5'd2, 1'b1, 32'h08000000, 1'b0, 1'b1);
    directed("sra",     4'b1101, 32'h80000001, 32'h24, 5'd2, 1'b1, 32'hF8000000, 1'b0, 1'b1);
    directed("sll0",    4'b0001, 32'h80000001, 32'h0,  5'd2, 1'b1, 32'h80000001, 1'b0, 1'b1);
    directed("srl0",    4'b0101, 32'h80000001, 32'h0,  5'd2, 1'b1, 32'h80000001, 1'b0, 1'b1);
    directed("sra0",    4'b1101, 32'h80000001, 32'h0,  5'd2, 1'b1, 32'h80000001, 1'b0, 1'b1);
    directed("xor",     4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd4, 1'b1, 32'hFF00FF00, 1'b0, 1'b1);
    directed("or",      4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd4, 1'b1, 32'hFFF0FFF0, 1'b0, 1'b1);
    directed("and",     4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd4, 1'b1, 32'h00F000F0, 1'b0, 1'b1);
    directed("b2b_add", 4'b0000, 32'd1, 32'd2, 5'd3, 1'b1, 32'd3, 1'b0, 1'b1);
    directed("b2b_or",  4'b0110, 32'd4, 32'd8, 5'd9, 1'b0, 32'd12, 1'b0, 1'b0);
    directed("illegal", 4'b1111, 32'h7FFFFFFF, 32'h1, 5'd10, 1'b1, 32'h0, 1'b0, 1'b0);
    directed("dest0",   4'b0000, 32'd10, 32'd20, 5'd0, 1'b1, 32'd30, 1'b0, 1'b1);

    // Random ops over all 16 codes, operands drawn from corners or full range.
    for (int i = 0; i < 400; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rd  = 5'($urandom);
      rwb = 1'($urandom);
      model(rop, ra, rb, rres, rovf, rlegal);
      drive(rop, ra, rb, rd, rwb);
      @(posedge clk_i); #1;
      chk($sformatf("rnd%0d.op%b.res", i, rop), res_o, rres);
      chk($sformatf("rnd%0d.op%b.ovf", i, rop), {31'h0, overflow_o}, {31'h0, rovf});
      chk($sformatf("rnd%0d.dest", i), {27'h0, reg_alu_dest_addr_o}, {27'h0, rd});
      chk($sformatf("rnd%0d.wb", i), {31'h0, alu_reg_wb_o}, {31'h0, rwb & rlegal});
    end

    // Asynchronous reset mid-cycle discards the captured result immediately.
    drive(4'b0000, 32'h7FFFFFFF, 32'h1, 5'd17, 1'b1);
    @(posedge clk_i); #2;
    rstn_i = 1'b0; #1;
    chk("arst.res", res_o, 32'h0);
    chk("arst.ovf", {31'h0, overflow_o}, 32'h0);
    chk("arst.dest", {27'h0, reg_alu_dest_addr_o}, 32'h0);
    chk("arst.wb", {31'h0, alu_reg_wb_o}, 32'h0);
    @(negedge clk_i); rstn_i = 1'b1;
    directed("post_rst", 4'b1000, 32'd100, 32'd1, 5'd8, 1'b1, 32'd99, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
